// File: rtl/tone_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tone_pkg : note table and state types shared by tone gen/detect      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tone_pkg;

   localparam int unsigned CLK_HZ = 50_000_000;

   typedef enum logic [2:0] {DO_L, RE, MI, FA, SO, LA, SI, DO_H} note_t;

   typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

   // Full square-wave periods in CLK_HZ cycles, indexed by note_t
   localparam int unsigned NOTE_PERIOD [8] = '{95602, 85179, 75873, 71633,
                                               63776, 56818, 50607, 47755};

endpackage
`default_nettype wire

// File: rtl/tone_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tone_sync_edge : 2-flop synchronizer with rising-edge pulse          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tone_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic edge_pulse
);

   logic meta;
   logic sync;
   logic prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= 1'b0;
         sync <= 1'b0;
         prev <= 1'b0;
      end else begin
         meta <= din;
         sync <= meta;
         prev <= sync;
      end
   end

   assign edge_pulse = sync & ~prev;

endmodule
`default_nettype wire

// File: rtl/tone_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tone_detector : measures tone_in period, decodes and locks on a note |
// | Optional macro TONE_DET_CHANGE_EN adds the note_change pulse output. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tone_detector
   import tone_pkg::*;
#(
   parameter int unsigned PERIOD_W   = 20,
   parameter int unsigned MAX_PERIOD = 131071,
   parameter int unsigned TOL_CYCLES = 1000,
   parameter int unsigned LOCK_COUNT = 4
) (
   input  logic                CLOCK_50M,
   input  logic                reset,
   input  logic                tone_in,
   output logic [2:0]          note,
   output logic                valid,
   output logic                no_tone,
`ifdef TONE_DET_CHANGE_EN
   output logic                note_change,
`endif
   output logic [PERIOD_W-1:0] period
);

   localparam int unsigned          LCW  = $clog2(LOCK_COUNT + 1);
   localparam logic [PERIOD_W-1:0] MAXP = PERIOD_W'(MAX_PERIOD);

   logic                edge_pulse;
   logic [PERIOD_W-1:0] period_cnt;
   logic [PERIOD_W-1:0] measured;
   logic                timeout;
   logic [31:0]         meas32;
   logic [31:0]         diff;
   logic                hit;
   note_t               hit_note;

   state_t              state, state_n;
   note_t               cand, cand_n;
   logic [LCW-1:0]      lock_cnt, lock_n;
   logic [2:0]          note_n;
   logic                valid_n;
   logic                no_tone_n;
   logic [PERIOD_W-1:0] period_n;

   tone_sync_edge u_sync (
      .clk        (CLOCK_50M),
      .reset      (reset),
      .din        (tone_in),
      .edge_pulse (edge_pulse)
   );

   always_ff @(posedge CLOCK_50M or posedge reset) begin
      if (reset)
         period_cnt <= '0;
      else if (edge_pulse)
         period_cnt <= '0;
      else if (period_cnt != MAXP)
         period_cnt <= period_cnt + 1'b1;
   end

   assign measured = (period_cnt == MAXP) ? MAXP : period_cnt + 1'b1;
   assign timeout  = (period_cnt == MAXP - 1'b1);
   assign meas32   = 32'(measured);

   // Scan high-to-low so the lowest matching index wins
   always_comb begin
      hit      = 1'b0;
      hit_note = DO_L;
      diff     = '0;
      for (int i = 7; i >= 0; i--) begin
         diff = (meas32 > NOTE_PERIOD[i]) ? meas32 - NOTE_PERIOD[i]
                                          : NOTE_PERIOD[i] - meas32;
         if (diff <= TOL_CYCLES) begin
            hit      = 1'b1;
            hit_note = note_t'(3'(i));
         end
      end
   end

   always_comb begin
      state_n   = state;
      cand_n    = cand;
      lock_n    = lock_cnt;
      note_n    = note;
      valid_n   = valid;
      no_tone_n = no_tone;
      period_n  = period;
      if (edge_pulse) begin
         case (state)
            IDLE: begin
               state_n   = ACQUIRE;
               no_tone_n = 1'b0;
               lock_n    = '0;
            end
            ACQUIRE: begin
               period_n = measured;
               if (hit && lock_cnt != '0 && hit_note == cand) begin
                  lock_n = lock_cnt + LCW'(1);
               end else if (hit) begin
                  lock_n = LCW'(1);
                  cand_n = hit_note;
               end else begin
                  lock_n = '0;
               end
               if (hit && lock_n == LCW'(LOCK_COUNT)) begin
                  state_n = LOCKED;
                  note_n  = hit_note;
                  valid_n = 1'b1;
               end
            end
            LOCKED: begin
               period_n = measured;
               if (!(hit && hit_note == note_t'(note))) begin
                  state_n = ACQUIRE;
                  valid_n = 1'b0;
                  lock_n  = hit ? LCW'(1) : '0;
                  if (hit)
                     cand_n = hit_note;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (timeout) begin
         state_n   = IDLE;
         no_tone_n = 1'b1;
         valid_n   = 1'b0;
         lock_n    = '0;
      end
   end

   always_ff @(posedge CLOCK_50M or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cand     <= DO_L;
         lock_cnt <= '0;
         note     <= '0;
         valid    <= 1'b0;
         no_tone  <= 1'b1;
         period   <= '0;
      end else begin
         state    <= state_n;
         cand     <= cand_n;
         lock_cnt <= lock_n;
         note     <= note_n;
         valid    <= valid_n;
         no_tone  <= no_tone_n;
         period   <= period_n;
      end
   end

`ifdef TONE_DET_CHANGE_EN
   // had_lock forgets the last note whenever the tone is lost
   logic had_lock;

   always_ff @(posedge CLOCK_50M or posedge reset) begin
      if (reset) begin
         had_lock    <= 1'b0;
         note_change <= 1'b0;
      end else begin
         note_change <= (state == ACQUIRE) && (state_n == LOCKED) &&
                        (!had_lock || note_n != note);
         if (state_n == IDLE)
            had_lock <= 1'b0;
         else if (state_n == LOCKED)
            had_lock <= 1'b1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tone_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tone_detector : directed vector bench for tone_detector           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tone_detector;

   typedef struct {
      int unsigned per;
      int unsigned edges;
      logic [2:0]  note;
      logic        valid;
      logic        no_tone;
      logic [19:0] period;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        tone_in;
   logic [2:0]  note;
   logic        valid;
   logic        no_tone;
   logic [19:0] period;
   int          n_cmp = 0;
   int          n_bad = 0;
   vec_t        v [15];

`ifdef TONE_DET_CHANGE_EN
   logic note_change;
   int   nc_cnt = 0;
   always @(negedge clk) if (note_change === 1'b1) nc_cnt = nc_cnt + 1;
`endif

   tone_detector dut (
      .CLOCK_50M   (clk),
      .reset       (reset),
      .tone_in     (tone_in),
      .note        (note),
      .valid       (valid),
      .no_tone     (no_tone),
`ifdef TONE_DET_CHANGE_EN
      .note_change (note_change),
`endif
      .period      (period)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [2:0] en, input logic ev,
                             input logic ent, input logic [19:0] ep);
      check({tag, " note"},    32'(note),    32'(en));
      check({tag, " valid"},   32'(valid),   32'(ev));
      check({tag, " no_tone"}, 32'(no_tone), 32'(ent));
      check({tag, " period"},  32'(period),  32'(ep));
   endtask

   // Each period: low phase, rising edge, high phase; checks land at period end
   task automatic send(input int unsigned per, input int unsigned edges);
      for (int e = 0; e < int'(edges); e++) begin
         tone_in = 1'b0;
         repeat (per - per / 2) @(negedge clk);
         tone_in = 1'b1;
         repeat (per / 2) @(negedge clk);
      end
   endtask

   task automatic run_vec(input int i);
      send(v[i].per, v[i].edges);
      check_outs($sformatf("v%0d", i), v[i].note, v[i].valid, v[i].no_tone, v[i].period);
   endtask

   initial begin
      // Transition periods mix the old high half with the new low half
      v[0]  = '{75873, 1, 3'd0, 1'b0, 1'b0, 20'd0};
      v[1]  = '{75873, 1, 3'd0, 1'b0, 1'b0, 20'd75873};
      v[2]  = '{75873, 2, 3'd0, 1'b0, 1'b0, 20'd75873};
      v[3]  = '{75873, 1, 3'd2, 1'b1, 1'b0, 20'd75873};
      v[4]  = '{47755, 1, 3'd2, 1'b0, 1'b0, 20'd61814};
      v[5]  = '{47755, 3, 3'd2, 1'b0, 1'b0, 20'd47755};
      v[6]  = '{47755, 1, 3'd7, 1'b1, 1'b0, 20'd47755};
      v[7]  = '{74000, 1, 3'd7, 1'b0, 1'b0, 20'd60877};
      v[8]  = '{74000, 7, 3'd7, 1'b0, 1'b0, 20'd74000};
      v[9]  = '{85179, 1, 3'd7, 1'b0, 1'b0, 20'd79590};
      v[10] = '{85179, 4, 3'd1, 1'b1, 1'b0, 20'd85179};
      v[11] = '{56818, 1, 3'd1, 1'b0, 1'b0, 20'd85179};
      v[12] = '{56818, 4, 3'd5, 1'b1, 1'b0, 20'd56818};
      v[13] = '{56818, 1, 3'd0, 1'b0, 1'b0, 20'd0};
      v[14] = '{56818, 4, 3'd5, 1'b1, 1'b0, 20'd56818};

      reset   = 1'b1;
      tone_in = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tone_in = ~tone_in;
         check_outs($sformatf("rst%0d", c), 3'd0, 1'b0, 1'b1, 20'd0);
      end
      @(negedge clk);
      reset   = 1'b0;
      tone_in = 1'b0;

      for (int i = 0; i <= 10; i++) run_vec(i);

      // Hold low after locking on RE: timeout lands MAX_PERIOD cycles after
      // the last edge_pulse, which fires 3 clocks after the rising edge
      tone_in = 1'b0;
      repeat (131073 - 42589) @(negedge clk);
      check_outs("pre_timeout", 3'd1, 1'b1, 1'b0, 20'd85179);
      @(negedge clk);
      check_outs("timeout", 3'd1, 1'b0, 1'b1, 20'd85179);

      for (int i = 11; i <= 12; i++) run_vec(i);

      // Mid-lock asynchronous reset, sampled before any clock edge
      reset = 1'b1;
      #1;
      check_outs("async_rst", 3'd0, 1'b0, 1'b1, 20'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;

      for (int i = 13; i <= 14; i++) run_vec(i);

`ifdef TONE_DET_CHANGE_EN
      check("note_change pulses", 32'(nc_cnt), 32'd5);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/tone_detector.md
Name: tone_detector

Overview:
- Receive-side counterpart of the square-wave tone generator. Measures the full period of an incoming square wave on tone_in, in CLOCK_50M cycles.
- Decodes the measured period to one of the eight scale notes, DO through high DO.
- After a stable lock, reports the note index, the raw period and a validity flag.
- Sits between an external or looped-back audio/GPIO pin and the LED/HEX display logic.

Parameters:
- PERIOD_W, 20: width of the period counter and the period output.
- MAX_PERIOD, 131071: cycles without a rising edge before declaring no tone.
- TOL_CYCLES, 1000: ± window around each nominal note period counted as a match.
- LOCK_COUNT, 4: consecutive matching periods (same note) required to assert valid.

Ports:
- CLOCK_50M  input  1  50 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- tone_in  input  1  asynchronous square-wave input.
- note  output  3  decoded note index: 0=DO523, 1=RE587, 2=MI659, 3=FA698, 4=SO784, 5=LA880, 6=SI988, 7=DO1047.
- valid  output  1  high while locked on a note.
- no_tone  output  1  high while no edge has been seen within MAX_PERIOD.
- period  output  PERIOD_W  last measured full period, in cycles.

Behaviour:
- Reset (async, active-high): note=0, valid=0, no_tone=1, period=0, state=IDLE. All counters and the synchronizer flops clear to 0.
- Input path: tone_in → 2-flop synchronizer → previous-sample flop.
  - edge_pulse is high for one cycle when sync=1 and prev=0.
  - An input rising edge produces edge_pulse 2–3 cycles later.
- Period counter:
  - Cleared to 0 in every edge_pulse cycle; increments by 1 in every other cycle.
  - Saturates at MAX_PERIOD.
  - Measured period at an edge = period_cnt+1, the exact cycle distance between consecutive edge_pulses.
- Nominal full periods (cycles), indices 0..7: 95602, 85179, 75873, 71633, 63776, 56818, 50607, 47755.
  - Match when |measured − nominal| ≤ TOL_CYCLES.
  - Windows are disjoint at the default tolerance; if several match, the lowest index wins.
- States:
  - IDLE: no_tone=1, valid=0. On the first edge_pulse → ACQUIRE. No period is measured from this first edge.
  - ACQUIRE:
    - On each edge_pulse: period updates to the measured value.
    - If it matches the same note as the previous period, lock_cnt increments; otherwise lock_cnt=1 (on a match) or 0 (no match).
    - When lock_cnt reaches LOCK_COUNT → LOCKED: note latched, valid=1.
  - LOCKED:
    - On each edge_pulse: period updates.
    - A matching period for the same note keeps the lock.
    - Any other result drops to ACQUIRE: valid=0 on the next cycle, note holds its last value, lock_cnt restarts from this period.
- Timeout: if period_cnt reaches MAX_PERIOD−1 with no edge_pulse, from any state → IDLE next cycle with no_tone=1 and valid=0. period holds its last value.
- no_tone clears in the cycle after the first edge_pulse out of IDLE.
- Simultaneous edge_pulse and timeout condition: the edge wins. The measured period is MAX_PERIOD, which matches no note, so it is processed as a mismatch.
- All outputs are registered and update in the cycle after the edge_pulse that caused them.
- Mid-operation reset forces the reset values immediately, regardless of state.

Optional Feature:
- Macro: TONE_DET_CHANGE_EN.
- Defined: adds output note_change (1 bit, reset 0), a one-cycle pulse on every ACQUIRE→LOCKED transition whose note differs from the previously locked note. The first lock after reset or after IDLE also pulses.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package tone_pkg:
  - note_t (3-bit enum DO_L, RE, MI, FA, SO, LA, SI, DO_H).
  - NOTE_PERIOD[8] constant array of nominal full periods.
  - CLK_HZ = 50_000_000.
  - The generator side shares this package so both ends use one table.
- Sub-module tone_sync_edge: 2-flop synchronizer plus rising-edge detector; outputs edge_pulse.

Test Plan:
- Reset high for 5 cycles with tone_in toggling → note=0, valid=0, no_tone=1, period=0 throughout.
- Square wave, period 75873 cycles (MI), 6 periods:
  - no_tone falls after the first edge.
  - period=75873 after the second edge.
  - valid=1 with note=2 after the 5th edge (4 matching periods).
- Locked on MI, then switch to period 47755 (high DO) → valid=0 after the first new period; note=7 and valid=1 after 4 further matching periods (TONE_DET_CHANGE_EN: one note_change pulse).
- Period 74000 (outside every window) for 8 periods → valid stays 0, period=74000, no_tone=0.
- Locked on RE (85179), then tone_in held low → no_tone=1 and valid=0 exactly MAX_PERIOD cycles after the last edge_pulse; period stays 85179.
- Assert reset mid-LOCKED, release, resume 56818-cycle wave → outputs reset immediately; relock to note=5 after 5 edges.
